ps2_input: RTL and testbench

PS2_INPUT -- requirements
Module: ps2_input

---
 rtl/ps2_input.sv | 139 +++++++++++++
 tb/tb_ps2_input.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_input.sv
// PS/2 keyboard receiver that tracks which of four direction keys are held.
// It accepts WASD and the extended arrow keys, handling the E0 (extended)
// and F0 (break) prefixes.
module ps2_input #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       switch,
  input  logic       PS2C,
  input  logic       PS2D,
  output logic [3:0] btnstate
);

  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] TIMEOUT_VAL = IW'(TIMEOUT_CYCLES);

  logic          c_sync1_reg, c_sync2_reg, c_prev_reg;
  logic          d_sync1_reg, d_sync2_reg;
  logic          fall_edge;
  logic [3:0]    bit_cnt_reg;
  logic [IW-1:0] idle_cnt_reg;
  logic [9:0]    frame_reg;
  logic [9:0]    frame_next;
  logic          frame_ok;
  logic          byte_valid_reg;
  logic [7:0]    byte_reg;
  logic          brk_reg, ext_reg;
  logic [3:0]    btn_reg;
  logic          key_hit;
  logic [1:0]    key_idx;

  // Two-flop synchronizers on both PS/2 lines, plus a history flop for edge detection.
  always_ff @(posedge clk) begin
    if (switch) begin
      c_sync1_reg <= 1'b1;
      c_sync2_reg <= 1'b1;
      c_prev_reg  <= 1'b1;
      d_sync1_reg <= 1'b1;
      d_sync2_reg <= 1'b1;
    end else begin
      c_sync1_reg <= PS2C;
      c_sync2_reg <= c_sync1_reg;
      c_prev_reg  <= c_sync2_reg;
      d_sync1_reg <= PS2D;
      d_sync2_reg <= d_sync1_reg;
    end
  end

  assign fall_edge = c_prev_reg & ~c_sync2_reg;

  // Each of the first ten frame positions captures PS2D when its slot's edge arrives.
  // The stop bit is used directly from the synchronizer and is never stored.
  generate
    for (genvar gi = 0; gi < 10; gi++) begin : g_frame_bit
      assign frame_next[gi] = (fall_edge && bit_cnt_reg == 4'(gi)) ? d_sync2_reg
                                                                   : frame_reg[gi];
    end
  endgenerate

  // The frame is checked while the stop bit is being sampled.
  // It needs start = 0, stop = 1, and odd parity over the data and parity bits.
  assign frame_ok = ~frame_reg[0] & d_sync2_reg & (^frame_reg[9:1]);

  // Bit position tracking, idle timeout, and handoff of a validated byte to the decoder.
  always_ff @(posedge clk) begin
    if (switch) begin
      bit_cnt_reg    <= 4'd0;
      idle_cnt_reg   <= '0;
      frame_reg      <= '0;
      byte_valid_reg <= 1'b0;
      byte_reg       <= 8'h00;
    end else begin
      frame_reg      <= frame_next;
      byte_valid_reg <= 1'b0;
      if (fall_edge) begin
        idle_cnt_reg <= '0;
        if (bit_cnt_reg == 4'd10) begin
          bit_cnt_reg    <= 4'd0;
          byte_valid_reg <= frame_ok;
          byte_reg       <= frame_reg[8:1];
        end else begin
          bit_cnt_reg <= bit_cnt_reg + 4'd1;
        end
      end else if (idle_cnt_reg == TIMEOUT_VAL) begin
        // The keyboard went quiet mid-frame, so drop the partial frame
        // and resynchronise on the next start bit.
        if (bit_cnt_reg != 4'd0) bit_cnt_reg <= 4'd0;
      end else begin
        idle_cnt_reg <= idle_cnt_reg + 1'b1;
      end
    end
  end

  // Map a completed scan code to a key index.
  // Letter codes count only without E0; arrow codes count only with E0.
  always_comb begin
    key_hit = 1'b0;
    key_idx = 2'd0;
    if (!ext_reg) begin
      case (byte_reg)
        8'h1D: begin key_hit = 1'b1; key_idx = 2'd0; end
        8'h1B: begin key_hit = 1'b1; key_idx = 2'd1; end
        8'h1C: begin key_hit = 1'b1; key_idx = 2'd2; end
        8'h23: begin key_hit = 1'b1; key_idx = 2'd3; end
        default: ;
      endcase
    end else begin
      case (byte_reg)
        8'h75: begin key_hit = 1'b1; key_idx = 2'd0; end
        8'h72: begin key_hit = 1'b1; key_idx = 2'd1; end
        8'h6B: begin key_hit = 1'b1; key_idx = 2'd2; end
        8'h74: begin key_hit = 1'b1; key_idx = 2'd3; end
        default: ;
      endcase
    end
  end

  // Prefix tracking and held-key register update.
  always_ff @(posedge clk) begin
    if (switch) begin
      brk_reg <= 1'b0;
      ext_reg <= 1'b0;
      btn_reg <= 4'b0000;
    end else if (byte_valid_reg) begin
      if (byte_reg == 8'hF0) begin
        brk_reg <= 1'b1;
      end else if (byte_reg == 8'hE0) begin
        ext_reg <= 1'b1;
      end else begin
        brk_reg <= 1'b0;
        ext_reg <= 1'b0;
        if (key_hit) btn_reg[key_idx] <= ~brk_reg;
      end
    end
  end

  assign btnstate = btn_reg;

endmodule

// File: tb/tb_ps2_input.sv
// Directed bench for ps2_input.
// It drives bit-level PS/2 frames and checks the held-key flags after each scenario.
module tb_ps2_input;

  localparam int TO   = 200;
  localparam int HALF = 10;

  logic       clk = 1'b0;
  logic       switch = 1'b0;
  logic       PS2C = 1'b1;
  logic       PS2D = 1'b1;
  logic [3:0] btnstate;

  int tests_run = 0;
  int tests_failed = 0;

  ps2_input #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .switch(switch), .PS2C(PS2C), .PS2D(PS2D), .btnstate(btnstate)
  );

  always #20 clk = ~clk;

  // Send up to nbits of a frame; the bus is returned to idle afterwards.
  task automatic send_frame(input logic [7:0] data, input bit bad_par,
                            input logic stop_val, input int nbits);
    logic [10:0] f;
    f[0]   = 1'b0;
    f[8:1] = data;
    f[9]   = (~^data) ^ bad_par;
    f[10]  = stop_val;
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      PS2D = f[i];
      PS2C = 1'b1;
      repeat (HALF) @(negedge clk);
      PS2C = 1'b0;
      repeat (HALF) @(negedge clk);
    end
    PS2C = 1'b1;
    PS2D = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] data);
    send_frame(data, 1'b0, 1'b1, 11);
  endtask

  task automatic do_reset();
    PS2C = 1'b1;
    PS2D = 1'b1;
    @(negedge clk);
    switch = 1'b1;
    repeat (3) @(negedge clk);
    switch = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    switch = 1'b1;
    @(negedge clk);
    switch = 1'b0;
    tests_run++;
    if (btnstate !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_state: got %b expected %b", btnstate, 4'b0000);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_make_break();
    do_reset();
    send(8'h1D);
    tests_run++;
    if (btnstate !== 4'b0001) begin
      tests_failed++;
      $display("FAIL make_w: got %b expected %b", btnstate, 4'b0001);
    end
    send(8'hF0);
    send(8'h1D);
    tests_run++;
    if (btnstate !== 4'b0000) begin
      tests_failed++;
      $display("FAIL break_w: got %b expected %b", btnstate, 4'b0000);
    end
  endtask

  task automatic test_extended();
    do_reset();
    send(8'hE0); send(8'h74);
    send(8'hE0); send(8'h6B);
    tests_run++;
    if (btnstate !== 4'b1100) begin
      tests_failed++;
      $display("FAIL ext_make: got %b expected %b", btnstate, 4'b1100);
    end
    send(8'hE0); send(8'hF0); send(8'h74);
    tests_run++;
    if (btnstate !== 4'b0100) begin
      tests_failed++;
      $display("FAIL ext_break: got %b expected %b", btnstate, 4'b0100);
    end
  endtask

  task automatic test_parity();
    do_reset();
    send_frame(8'h23, 1'b1, 1'b1, 11);
    tests_run++;
    if (btnstate !== 4'b0000) begin
      tests_failed++;
      $display("FAIL bad_parity: got %b expected %b", btnstate, 4'b0000);
    end
    send(8'h23);
    tests_run++;
    if (btnstate !== 4'b1000) begin
      tests_failed++;
      $display("FAIL good_after_bad: got %b expected %b", btnstate, 4'b1000);
    end
    // A corrupted F0 must not arm break, so the following 1D is a make.
    send_frame(8'hF0, 1'b1, 1'b1, 11);
    send(8'h1D);
    tests_run++;
    if (btnstate !== 4'b1001) begin
      tests_failed++;
      $display("FAIL bad_f0_ignored: got %b expected %b", btnstate, 4'b1001);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    send_frame(8'h55, 1'b0, 1'b1, 5);
    repeat (TO + 10) @(negedge clk);
    send(8'h1B);
    tests_run++;
    if (btnstate !== 4'b0010) begin
      tests_failed++;
      $display("FAIL timeout_resync: got %b expected %b", btnstate, 4'b0010);
    end
  endtask

  task automatic test_reset_midframe();
    do_reset();
    send(8'h1D); send(8'h1B); send(8'h1C); send(8'h23);
    tests_run++;
    if (btnstate !== 4'b1111) begin
      tests_failed++;
      $display("FAIL all_held: got %b expected %b", btnstate, 4'b1111);
    end
    send_frame(8'h1B, 1'b0, 1'b1, 5);
    @(negedge clk);
    switch = 1'b1;
    @(negedge clk);
    switch = 1'b0;
    tests_run++;
    if (btnstate !== 4'b0000) begin
      tests_failed++;
      $display("FAIL midframe_reset: got %b expected %b", btnstate, 4'b0000);
    end
    send(8'h1C);
    tests_run++;
    if (btnstate !== 4'b0100) begin
      tests_failed++;
      $display("FAIL after_reset_key: got %b expected %b", btnstate, 4'b0100);
    end
  endtask

  task automatic test_ignored();
    do_reset();
    send(8'h75);
    tests_run++;
    if (btnstate !== 4'b0000) begin
      tests_failed++;
      $display("FAIL bare_arrow: got %b expected %b", btnstate, 4'b0000);
    end
    send(8'hE0); send(8'h1D);
    tests_run++;
    if (btnstate !== 4'b0000) begin
      tests_failed++;
      $display("FAIL ext_letter: got %b expected %b", btnstate, 4'b0000);
    end
    send_frame(8'h1D, 1'b0, 1'b0, 11);
    tests_run++;
    if (btnstate !== 4'b0000) begin
      tests_failed++;
      $display("FAIL bad_stop: got %b expected %b", btnstate, 4'b0000);
    end
    // The prefix must have cleared after the ignored 1D, so this is a plain W make.
    send(8'h1D);
    tests_run++;
    if (btnstate !== 4'b0001) begin
      tests_failed++;
      $display("FAIL prefix_cleared: got %b expected %b", btnstate, 4'b0001);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    send(8'h1D); send(8'h1D);
    send(8'hE0); send(8'h72);
    tests_run++;
    if (btnstate !== 4'b0011) begin
      tests_failed++;
      $display("FAIL typematic_updown: got %b expected %b", btnstate, 4'b0011);
    end
    send(8'hF0); send(8'h23);
    tests_run++;
    if (btnstate !== 4'b0011) begin
      tests_failed++;
      $display("FAIL break_not_held: got %b expected %b", btnstate, 4'b0011);
    end
    send(8'hE0); send(8'hF0); send(8'h75);
    tests_run++;
    if (btnstate !== 4'b0010) begin
      tests_failed++;
      $display("FAIL ext_break_up: got %b expected %b", btnstate, 4'b0010);
    end
  endtask

  initial begin
    test_reset();
    test_make_break();
    test_extended();
    test_parity();
    test_timeout();
    test_reset_midframe();
    test_ignored();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
